mem_port_arbiter: RTL and testbench

Parametrised N-channel memory port arbiter for the pipelined RV32I core. It multiplexes independent requesters onto the single shared `mem_*` port, for example the I-cache, D-cache and a future DMA or prefetcher. It uses the same read/write/resp handshake and word-aligned addressing that the multicycle core drives. One transaction is outstanding at a time. Request fields are registered, and arbitration between channels is either fixed-priority or round-robin.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/arb_picker.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, channel index, latched request.
// Struct widths follow the default 32-bit address/data configuration.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;
  localparam int ARB_OFS_W  = $clog2(ARB_BE_W);
  localparam int ARB_MAX_CH = 8;
  localparam int CH_IDX_W   = $clog2(ARB_MAX_CH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

  function automatic logic [ARB_ADDR_W-1:0] word_align(input logic [ARB_ADDR_W-1:0] a);
    return {a[ARB_ADDR_W-1:ARB_OFS_W], {ARB_OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundle of the arbiter; slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_CH-1:0]            ch_read;
  logic [NUM_CH-1:0]            ch_write;
  logic [NUM_CH-1:0][BE_W-1:0]  ch_byte_enable;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_address;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]            ch_resp;
  logic [DATA_W-1:0]            ch_rdata;

  logic                         mem_read;
  logic                         mem_write;
  logic [BE_W-1:0]              mem_byte_enable;
  logic [ADDR_W-1:0]            mem_address;
  logic [DATA_W-1:0]            mem_wdata;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         mem_resp;

  modport slave (
    input  ch_read, ch_write, ch_byte_enable, ch_address, ch_wdata, mem_rdata, mem_resp,
    output ch_resp, ch_rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

  modport master (
    output ch_read, ch_write, ch_byte_enable, ch_address, ch_wdata, mem_rdata, mem_resp,
    input  ch_resp, ch_rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

endinterface

// File: rtl/arb_picker.sv
// Combinational channel picker: fixed priority (lowest index) by default,
// round-robin starting after ptr when MEM_ARB_RR_EN is defined.
module arb_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  ch_idx_t           ptr_i,
  output logic              vld_o,
  output ch_idx_t           idx_o
);
  localparam int IW = $clog2(NUM_CH);

  logic [IW-1:0] cand;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = IW'((int'(ptr_i) + k) % NUM_CH);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = ch_idx_t'(cand);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = IW'(k);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = ch_idx_t'(cand);
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter onto one memory port, one transaction outstanding; request fields are
// registered, response is passed straight through. Round-robin when MEM_ARB_RR_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_CH);

  arb_state_t        state_q;
  ch_idx_t           grant_q;
  arb_req_t          req_q;
  arb_req_t          req_d;
  logic [NUM_CH-1:0] ch_req;
  logic              pick_vld;
  ch_idx_t           pick_idx;
  ch_idx_t           ptr;
  logic [IW-1:0]     sel;

  assign ch_req = bus.ch_read | bus.ch_write;
  assign sel    = pick_idx[IW-1:0];

`ifdef MEM_ARB_RR_EN
  ch_idx_t ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  arb_picker #(.NUM_CH(NUM_CH)) u_picker (
    .req_i (ch_req),
    .ptr_i (ptr),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  // Write wins when a channel raises read and write together.
  always_comb begin
    req_d       = '0;
    req_d.wr    = bus.ch_write[sel];
    req_d.rd    = bus.ch_read[sel] & ~bus.ch_write[sel];
    req_d.be    = bus.ch_byte_enable[sel];
    req_d.addr  = word_align(bus.ch_address[sel]);
    req_d.wdata = bus.ch_wdata[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      req_q   <= '0;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= ch_idx_t'(NUM_CH - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= BUSY;
            grant_q <= pick_idx;
            req_q   <= req_d;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= pick_idx;
`endif
          end
        end
        BUSY: begin
          // Clearing the request here keeps every mem_* output at 0 while idle.
          if (bus.mem_resp) begin
            state_q <= IDLE;
            req_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_read        = req_q.rd;
  assign bus.mem_write       = req_q.wr;
  assign bus.mem_byte_enable = req_q.be;
  assign bus.mem_address     = req_q.addr;
  assign bus.mem_wdata       = req_q.wdata;

  assign bus.ch_resp  = (state_q == BUSY && bus.mem_resp && !rst) ? (NUM_CH'(1) << grant_q) : '0;
  assign bus.ch_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with three channels; arbitration expectations
// switch with MEM_ARB_RR_EN.
module tb_mem_port_arbiter;
  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_port_arbiter_if #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd"},   32'(bus.mem_read), 32'd0);
    chk({tag, "_wr"},   32'(bus.mem_write), 32'd0);
    chk({tag, "_resp"}, 32'(bus.ch_resp), 32'd0);
  endtask

  int first_ch;
  int second_ch;
  int exp_ch;

  initial begin
    bus.ch_read        = '0;
    bus.ch_write       = '0;
    bus.ch_byte_enable = '0;
    bus.ch_address     = '0;
    bus.ch_wdata       = '0;
    bus.mem_rdata      = '0;
    bus.mem_resp       = 1'b0;

    // Reset state
    tick();
    tick();
    chk_idle("rst");
    chk("rst_be",   32'(bus.mem_byte_enable), 32'd0);
    chk("rst_addr", bus.mem_address, 32'd0);
    chk("rst_wd",   bus.mem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // Single read, answered after 3 cycles
    bus.ch_read[0]        = 1'b1;
    bus.ch_address[0]     = 32'h0000_1006;
    bus.ch_byte_enable[0] = 4'hF;
    tick();
    chk("t1_rd",   32'(bus.mem_read), 32'd1);
    chk("t1_wr",   32'(bus.mem_write), 32'd0);
    chk("t1_addr", bus.mem_address, 32'h0000_1004);
    chk("t1_be",   32'(bus.mem_byte_enable), 32'hF);
    chk("t1_noresp", 32'(bus.ch_resp), 32'd0);
    tick();
    tick();
    chk("t1_hold", bus.mem_address, 32'h0000_1004);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_resp",  32'(bus.ch_resp), 32'b001);
    chk("t1_rdata", bus.ch_rdata, 32'hDEAD_BEEF);
    tick();
    bus.mem_resp   = 1'b0;
    bus.ch_read[0] = 1'b0;
    chk_idle("t1_after");
    tick();
    chk_idle("t1_quiet");

    // Two simultaneous requests
`ifdef MEM_ARB_RR_EN
    first_ch  = 1;
    second_ch = 0;
`else
    first_ch  = 0;
    second_ch = 1;
`endif
    bus.ch_read[0]    = 1'b1;
    bus.ch_address[0] = 32'h0000_0100;
    bus.ch_read[1]    = 1'b1;
    bus.ch_address[1] = 32'h0000_0200;
    tick();
    chk("t2_a_rd",   32'(bus.mem_read), 32'd1);
    chk("t2_a_addr", bus.mem_address, 32'h100 * (first_ch + 1));
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h0000_0011;
    #1;
    chk("t2_a_resp", 32'(bus.ch_resp), 32'(1 << first_ch));
    tick();
    bus.mem_resp          = 1'b0;
    bus.ch_read[first_ch] = 1'b0;
    chk_idle("t2_gap");
    tick();
    chk("t2_b_rd",   32'(bus.mem_read), 32'd1);
    chk("t2_b_addr", bus.mem_address, 32'h100 * (second_ch + 1));
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h0000_0022;
    #1;
    chk("t2_b_resp",  32'(bus.ch_resp), 32'(1 << second_ch));
    chk("t2_b_rdata", bus.ch_rdata, 32'h0000_0022);
    tick();
    bus.mem_resp           = 1'b0;
    bus.ch_read[second_ch] = 1'b0;
    tick();

    // Read and write together on ch1
    bus.ch_read[1]        = 1'b1;
    bus.ch_write[1]       = 1'b1;
    bus.ch_byte_enable[1] = 4'b0011;
    bus.ch_wdata[1]       = 32'h1234_5678;
    bus.ch_address[1]     = 32'h0000_0303;
    tick();
    chk("t4_wr",   32'(bus.mem_write), 32'd1);
    chk("t4_rd",   32'(bus.mem_read), 32'd0);
    chk("t4_be",   32'(bus.mem_byte_enable), 32'b0011);
    chk("t4_wd",   bus.mem_wdata, 32'h1234_5678);
    chk("t4_addr", bus.mem_address, 32'h0000_0300);
    bus.ch_wdata[1] = 32'hFFFF_0000;
    tick();
    chk("t4_hold", bus.mem_wdata, 32'h1234_5678);
    bus.mem_resp = 1'b1;
    #1;
    chk("t4_resp", 32'(bus.ch_resp), 32'b010);
    tick();
    bus.mem_resp    = 1'b0;
    bus.ch_read[1]  = 1'b0;
    bus.ch_write[1] = 1'b0;
    tick();

    // Reset while busy, with a response in the same cycle
    bus.ch_read[2]    = 1'b1;
    bus.ch_address[2] = 32'h0000_0404;
    tick();
    chk("t5_busy", 32'(bus.mem_read), 32'd1);
    rst          = 1'b1;
    bus.mem_resp = 1'b1;
    #1;
    chk("t5_noresp", 32'(bus.ch_resp), 32'd0);
    tick();
    chk_idle("t5_after");
    chk("t5_addr", bus.mem_address, 32'd0);
    chk("t5_be",   32'(bus.mem_byte_enable), 32'd0);
    rst            = 1'b0;
    bus.mem_resp   = 1'b0;
    bus.ch_read[2] = 1'b0;
    tick();
    chk_idle("t5_idle");

    // Spurious response in idle
    bus.mem_resp = 1'b1;
    #1;
    chk("t6_resp", 32'(bus.ch_resp), 32'd0);
    tick();
    chk_idle("t6_after");
    bus.mem_resp = 1'b0;
    tick();

    // All channels requesting continuously
    for (int c = 0; c < NCH; c++) begin
      bus.ch_read[c]    = 1'b1;
      bus.ch_address[c] = 32'h0000_1000 + 32'(c * 16);
    end
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_ch = k % NCH;
`else
      exp_ch = 0;
`endif
      tick();
      chk("t3_rd",   32'(bus.mem_read), 32'd1);
      chk("t3_addr", bus.mem_address, 32'h0000_1000 + 32'(exp_ch * 16));
      bus.mem_resp = 1'b1;
      #1;
      chk("t3_resp", 32'(bus.ch_resp), 32'(1 << exp_ch));
      tick();
      bus.mem_resp = 1'b0;
      chk_idle("t3_gap");
    end
    bus.ch_read = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
